// File: rtl/control_unit_if.sv
// control_unit_if
// Bundles the signals between the control unit and the datapath.
//   master : control unit side. It receives IR and SF and drives the
//            control word, the state (for debug) and halted.
//   slave  : datapath side, with the opposite directions.
// Signals:
//   IR[31:0]      instruction word from the instruction register
//   SF[3:0]       status flags {V,C,N,Z}
//   AS            address select (0 ALU, 1 PC)
//   DS[1:0]       data select (00 ALU, 01 B, 10 PC, 11 memory)
//   PS[1:0]       PC function (00 hold, 01 inc, 10 load, 11 PC+PC_in)
//   PC_Sel        PC_in source (0 A bus, 1 K)
//   K_Sel         ALU B source (0 B bus, 1 K)
//   IL, SL        instruction load, status load
//   FS[4:0], C0   ALU function select and carry-in
//   MW, RW        memory write, register-file write
//   DA, SA, SB    register-file addresses
//   K[63:0]       constant
//   state[2:0]    current FSM state
//   halted        high while halted
interface control_unit_if;
   logic [31:0] IR;
   logic [3:0]  SF;
   logic        AS;
   logic [1:0]  DS;
   logic [1:0]  PS;
   logic        PC_Sel;
   logic        K_Sel;
   logic        IL;
   logic        SL;
   logic [4:0]  FS;
   logic        C0;
   logic        MW;
   logic        RW;
   logic [4:0]  DA;
   logic [4:0]  SA;
   logic [4:0]  SB;
   logic [63:0] K;
   logic [2:0]  state;
   logic        halted;

   modport master (
      input  IR, SF,
      output AS, DS, PS, PC_Sel, K_Sel, IL, SL, FS, C0, MW, RW,
             DA, SA, SB, K, state, halted
   );

   modport slave (
      output IR, SF,
      input  AS, DS, PS, PC_Sel, K_Sel, IL, SL, FS, C0, MW, RW,
             DA, SA, SB, K, state, halted
   );
endinterface

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle instruction sequencer. It runs FETCH, DECODE and EXECUTE
// (plus MEM for loads) and decodes the instruction register into a
// control word for the datapath.
// Ports:
//   clk   rising-edge clock for the state register
//   rst   asynchronous, active-high reset that forces the INIT state
//   bus   control_unit_if.master, which carries IR/SF in and the
//         control word, state and halted out
// Parameter:
//   FS_ADD  ALU function code used for load/store address calculation
module control_unit #(
   parameter logic [4:0] FS_ADD = 5'b00010
) (
   input logic            clk,
   input logic            rst,
   control_unit_if.master bus
);

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_MEM     = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   localparam logic [5:0] OP_ALUR  = 6'h01;
   localparam logic [5:0] OP_ALUI  = 6'h02;
   localparam logic [5:0] OP_LOAD  = 6'h03;
   localparam logic [5:0] OP_STORE = 6'h04;
   localparam logic [5:0] OP_B     = 6'h05;
   localparam logic [5:0] OP_BCOND = 6'h06;
   localparam logic [5:0] OP_BR    = 6'h07;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   state_t      cur_state;
   state_t      nxt_state;

   logic [5:0]  op;
   logic [4:0]  rd, rn, rm, fs;
   logic [10:0] imm11;
   logic [18:0] imm19;
   logic [25:0] imm26;
   logic [3:0]  cond;
   logic        cond_true;

   assign op    = bus.IR[31:26];
   assign rd    = bus.IR[25:21];
   assign rn    = bus.IR[20:16];
   assign rm    = bus.IR[15:11];
   assign imm11 = bus.IR[15:5];
   assign fs    = bus.IR[4:0];
   assign imm19 = bus.IR[23:5];
   assign cond  = bus.IR[3:0];
   assign imm26 = bus.IR[25:0];

   // Branch condition evaluation. The flags are packed {V,C,N,Z}, so Z is
   // bit 0 and V is bit 3. Codes 8-15 are reserved and never taken.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'd0: cond_true =  bus.SF[0];
         4'd1: cond_true = ~bus.SF[0];
         4'd2: cond_true =  bus.SF[2];
         4'd3: cond_true = ~bus.SF[2];
         4'd4: cond_true =  bus.SF[1];
         4'd5: cond_true = ~bus.SF[1];
         4'd6: cond_true =  bus.SF[3];
         4'd7: cond_true = ~bus.SF[3];
         default: cond_true = 1'b0;
      endcase
   end

   // State register. Reset is asynchronous so an in-flight instruction
   // is abandoned at once. The control word follows the state
   // combinationally, so no write strobe can survive a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= ST_INIT;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Control word and next-state decode. Every output starts at zero, and
   // each state or opcode raises only the fields it needs. MEM repeats
   // the load address setup so the memory address stays stable while the
   // read data is written back. Branch offsets are added to the PC that
   // was already incremented in DECODE.
   always_comb begin
      bus.AS     = 1'b0;
      bus.DS     = 2'b00;
      bus.PS     = 2'b00;
      bus.PC_Sel = 1'b0;
      bus.K_Sel  = 1'b0;
      bus.IL     = 1'b0;
      bus.SL     = 1'b0;
      bus.FS     = 5'd0;
      bus.C0     = 1'b0;
      bus.MW     = 1'b0;
      bus.RW     = 1'b0;
      bus.DA     = 5'd0;
      bus.SA     = 5'd0;
      bus.SB     = 5'd0;
      bus.K      = 64'd0;
      bus.halted = 1'b0;
      nxt_state  = ST_INIT;

      case (cur_state)
         ST_INIT: begin
            nxt_state = ST_FETCH;
         end
         ST_FETCH: begin
            bus.AS    = 1'b1;
            bus.DS    = 2'b11;
            bus.IL    = 1'b1;
            nxt_state = ST_DECODE;
         end
         ST_DECODE: begin
            bus.PS    = 2'b01;
            nxt_state = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            nxt_state = ST_FETCH;
            case (op)
               OP_ALUR: begin
                  bus.DA = rd;
                  bus.SA = rn;
                  bus.SB = rm;
                  bus.FS = fs;
                  bus.RW = 1'b1;
                  bus.SL = bus.IR[5];
                  bus.C0 = bus.IR[6];
               end
               OP_ALUI: begin
                  bus.DA    = rd;
                  bus.SA    = rn;
                  bus.FS    = fs;
                  bus.K_Sel = 1'b1;
                  bus.K     = {53'd0, imm11};
                  bus.RW    = 1'b1;
                  bus.SL    = 1'b1;
               end
               OP_LOAD: begin
                  bus.SA    = rn;
                  bus.K     = {53'd0, imm11};
                  bus.K_Sel = 1'b1;
                  bus.FS    = FS_ADD;
                  bus.DS    = 2'b11;
                  nxt_state = ST_MEM;
               end
               OP_STORE: begin
                  bus.SA    = rn;
                  bus.SB    = rd;
                  bus.K     = {53'd0, imm11};
                  bus.K_Sel = 1'b1;
                  bus.FS    = FS_ADD;
                  bus.MW    = 1'b1;
               end
               OP_B: begin
                  bus.K      = {{38{imm26[25]}}, imm26};
                  bus.PC_Sel = 1'b1;
                  bus.PS     = 2'b11;
               end
               OP_BCOND: begin
                  if (cond_true) begin
                     bus.K      = {{45{imm19[18]}}, imm19};
                     bus.PC_Sel = 1'b1;
                     bus.PS     = 2'b11;
                  end
               end
               OP_BR: begin
                  bus.SA = rn;
                  bus.PS = 2'b10;
               end
               OP_HALT: begin
                  nxt_state = ST_HALT;
               end
               default: begin
                  nxt_state = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            bus.SA    = rn;
            bus.K     = {53'd0, imm11};
            bus.K_Sel = 1'b1;
            bus.FS    = FS_ADD;
            bus.DS    = 2'b11;
            bus.DA    = rd;
            bus.RW    = 1'b1;
            nxt_state = ST_FETCH;
         end
         ST_HALT: begin
            bus.halted = 1'b1;
            nxt_state  = ST_HALT;
         end
         default: begin
            nxt_state = ST_INIT;
         end
      endcase
   end

   assign bus.state = cur_state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Bench for control_unit. A behavioural model computes the expected
// control word and state sequence from the instruction field rules. The
// bench applies directed scenarios, random instructions and
// mid-instruction resets.
module tb_control_unit;

   localparam logic [4:0] EXP_FS_ADD = 5'b00010;
   localparam int S_INIT = 0, S_FETCH = 1, S_DECODE = 2, S_EXECUTE = 3, S_MEM = 4, S_HALT = 5;

   typedef struct packed {
      logic        AS;
      logic [1:0]  DS;
      logic [1:0]  PS;
      logic        PC_Sel;
      logic        K_Sel;
      logic        IL;
      logic        SL;
      logic [4:0]  FS;
      logic        C0;
      logic        MW;
      logic        RW;
      logic [4:0]  DA;
      logic [4:0]  SA;
      logic [4:0]  SB;
      logic [63:0] K;
      logic        halted;
   } cw_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   model_state;

   control_unit_if bus ();

   control_unit #(.FS_ADD(EXP_FS_ADD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model of the control word. It extracts fields with integer
   // arithmetic and maps branch conditions to flag bits through a lookup.
   function automatic cw_t model_word(int st, logic [31:0] ir, logic [3:0] sf);
      cw_t         w;
      int unsigned u;
      int          op, rd, rn, rm, fs, imm11, imm19, imm26, cond, flag_idx;
      longint      off19, off26;
      logic        flag, taken;
      int          flag_of_pair [4];
      flag_of_pair = '{0, 2, 1, 3};
      w     = '0;
      u     = ir;
      op    = int'(u / (2**26));
      rd    = int'((u / (2**21)) % 32);
      rn    = int'((u / (2**16)) % 32);
      rm    = int'((u / (2**11)) % 32);
      imm11 = int'((u / 32) % 2048);
      fs    = int'(u % 32);
      imm19 = int'((u / 32) % (2**19));
      imm26 = int'(u % (2**26));
      cond  = int'(u % 16);
      off19 = imm19;
      if (off19 >= 2**18) off19 = off19 - 2**19;
      off26 = imm26;
      if (off26 >= 2**25) off26 = off26 - 2**26;
      flag_idx = flag_of_pair[(cond / 2) % 4];
      flag  = sf[flag_idx];
      taken = (cond < 8) && (((cond % 2) == 0) ? flag : !flag);
      if (st == S_FETCH) begin
         w.AS = 1'b1; w.DS = 2'b11; w.IL = 1'b1;
      end else if (st == S_DECODE) begin
         w.PS = 2'b01;
      end else if (st == S_HALT) begin
         w.halted = 1'b1;
      end else if (st == S_MEM || (st == S_EXECUTE && op == 3)) begin
         w.SA = 5'(rn); w.K = 64'(imm11); w.K_Sel = 1'b1; w.FS = EXP_FS_ADD; w.DS = 2'b11;
         if (st == S_MEM) begin
            w.DA = 5'(rd); w.RW = 1'b1;
         end
      end else if (st == S_EXECUTE) begin
         if (op == 1) begin
            w.DA = 5'(rd); w.SA = 5'(rn); w.SB = 5'(rm); w.FS = 5'(fs); w.RW = 1'b1;
            w.SL = ((u / 32) % 2) == 1; w.C0 = ((u / 64) % 2) == 1;
         end else if (op == 2) begin
            w.DA = 5'(rd); w.SA = 5'(rn); w.FS = 5'(fs); w.K_Sel = 1'b1;
            w.K = 64'(imm11); w.RW = 1'b1; w.SL = 1'b1;
         end else if (op == 4) begin
            w.SA = 5'(rn); w.SB = 5'(rd); w.K = 64'(imm11); w.K_Sel = 1'b1;
            w.FS = EXP_FS_ADD; w.MW = 1'b1;
         end else if (op == 5) begin
            w.K = 64'(off26); w.PC_Sel = 1'b1; w.PS = 2'b11;
         end else if (op == 6 && taken) begin
            w.K = 64'(off19); w.PC_Sel = 1'b1; w.PS = 2'b11;
         end else if (op == 7) begin
            w.SA = 5'(rn); w.PS = 2'b10;
         end
      end
      return w;
   endfunction

   // Reference model of the state sequence.
   function automatic int model_next(int st, logic [31:0] ir);
      int op;
      op = int'(ir[31:26]);
      if (st == S_EXECUTE) return (op == 3) ? S_MEM : (op == 63) ? S_HALT : S_FETCH;
      if (st == S_HALT) return S_HALT;
      if (st == S_MEM) return S_FETCH;
      return st + 1;
   endfunction

   function automatic cw_t observed_word();
      cw_t w;
      w = '{bus.AS, bus.DS, bus.PS, bus.PC_Sel, bus.K_Sel, bus.IL, bus.SL, bus.FS,
            bus.C0, bus.MW, bus.RW, bus.DA, bus.SA, bus.SB, bus.K, bus.halted};
      return w;
   endfunction

   // Compares the DUT state and control word against the model.
   task automatic checkOutput(input string tag);
      cw_t exp_w, obs_w;
      exp_w = model_word(model_state, bus.IR, bus.SF);
      obs_w = observed_word();
      checks++;
      assert (bus.state === 3'(model_state)) else begin
         errors++;
         $error("[TB] FAIL %s_state: observed %0d required %0d", tag, bus.state, model_state);
      end
      checks++;
      assert (obs_w === exp_w) else begin
         errors++;
         $error("[TB] FAIL %s_word: observed %h required %h", tag, obs_w, exp_w);
      end
   endtask

   // Compares one directly named value against a fixed expectation.
   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Drives new instruction and flags, then checks the settled outputs.
   task automatic applyStimulus(input logic [31:0] ir, input logic [3:0] sf, input string tag);
      bus.IR = ir;
      bus.SF = sf;
      #1;
      checkOutput(tag);
   endtask

   // Advances one clock edge, updates the model state and checks.
   task automatic tick(input string tag);
      int nxt;
      nxt = model_next(model_state, bus.IR);
      @(posedge clk);
      #1;
      model_state = nxt;
      checkOutput(tag);
   endtask

   // Runs one full instruction starting from FETCH.
   task automatic run_instr(input logic [31:0] ir, input logic [3:0] sf, input string tag);
      bit done;
      done = 1'b0;
      applyStimulus(ir, sf, tag);
      for (int i = 0; i < 6 && !done; i++) begin
         tick(tag);
         if (model_state == S_FETCH || model_state == S_HALT) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: observed state %0d required FETCH", tag, bus.state);
      end
   endtask

   // Asserts rst between edges and checks that outputs clear at once.
   task automatic async_reset(input string tag);
      #1;
      rst = 1'b1;
      model_state = S_INIT;
      #1;
      checkOutput(tag);
      check_value({tag, "_rw"}, 64'(bus.RW), 64'd0);
      check_value({tag, "_mw"}, 64'(bus.MW), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput({tag, "_release"});
   endtask

   initial begin
      logic [31:0] ir;
      logic [5:0]  op;
      logic [5:0]  op_pool [9];
      op_pool = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h2A};
      checks = 0;
      errors = 0;
      model_state = S_INIT;
      rst = 1'b1;
      bus.IR = 32'd0;
      bus.SF = 4'd0;
      #1;
      checkOutput("reset");
      check_value("reset_halted", 64'(bus.halted), 64'd0);
      #20;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("init");

      // ALU-R: Rd=1, Rn=2, Rm=3, fs=2.
      bus.IR = 32'h0422_1802;
      tick("fetch");
      check_value("fetch_as", 64'(bus.AS), 64'd1);
      check_value("fetch_ds", 64'(bus.DS), 64'd3);
      check_value("fetch_il", 64'(bus.IL), 64'd1);
      tick("decode");
      check_value("decode_ps", 64'(bus.PS), 64'd1);
      tick("alur_exec");
      check_value("alur_state", 64'(bus.state), 64'd3);
      check_value("alur_da", 64'(bus.DA), 64'd1);
      check_value("alur_sa", 64'(bus.SA), 64'd2);
      check_value("alur_sb", 64'(bus.SB), 64'd3);
      check_value("alur_fs", 64'(bus.FS), 64'd2);
      check_value("alur_rw", 64'(bus.RW), 64'd1);
      check_value("alur_ds", 64'(bus.DS), 64'd0);
      check_value("alur_sl", 64'(bus.SL), 64'd0);
      tick("alur_next");
      check_value("alur_next_state", 64'(bus.state), 64'd1);

      // LOAD with Rd=4, Rn=5, imm11=8 visits MEM before FETCH.
      applyStimulus((32'd3 << 26) | (32'd4 << 21) | (32'd5 << 16) | (32'd8 << 5), 4'd0, "load_fetch");
      tick("load_decode");
      tick("load_exec");
      check_value("load_k", bus.K, 64'd8);
      check_value("load_as", 64'(bus.AS), 64'd0);
      check_value("load_ds", 64'(bus.DS), 64'd3);
      check_value("load_rw", 64'(bus.RW), 64'd0);
      tick("load_mem");
      check_value("mem_state", 64'(bus.state), 64'd4);
      check_value("mem_da", 64'(bus.DA), 64'd4);
      check_value("mem_rw", 64'(bus.RW), 64'd1);
      tick("load_next");
      check_value("load_next_state", 64'(bus.state), 64'd1);

      // B.cond on Z with offset -2, checked both taken and not taken.
      applyStimulus((32'd6 << 26) | (32'h7FFFE << 5), 4'b0001, "bcond_fetch");
      tick("bcond_decode");
      tick("bcond_taken");
      check_value("bcond_taken_ps", 64'(bus.PS), 64'd3);
      check_value("bcond_taken_k", bus.K, 64'hFFFF_FFFF_FFFF_FFFE);
      applyStimulus(bus.IR, 4'b0000, "bcond_not_taken");
      check_value("bcond_not_taken_ps", 64'(bus.PS), 64'd0);
      tick("bcond_next");

      // Undefined opcode gives the default word.
      applyStimulus((32'h2A << 26) | 32'h0123_4567 % (32'd1 << 26), 4'hF, "undef_fetch");
      tick("undef_decode");
      tick("undef_exec");
      check_value("undef_wr", {62'd0, bus.RW, bus.MW}, 64'd0);
      check_value("undef_il", 64'(bus.IL), 64'd0);
      check_value("undef_ps", 64'(bus.PS), 64'd0);
      tick("undef_next");

      // Random instruction stream, with HALT excluded.
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            op = 6'($urandom_range(0, 62));
         end else begin
            op = op_pool[$urandom_range(0, 8)];
         end
         ir = {op, 26'($urandom)};
         run_instr(ir, 4'($urandom), "rand");
      end

      // Reset while MEM drives RW high.
      applyStimulus((32'd3 << 26) | 32'($urandom_range(0, (1 << 26) - 1)), 4'd0, "rmem_fetch");
      tick("rmem_decode");
      tick("rmem_exec");
      tick("rmem_mem");
      async_reset("rst_in_mem");
      tick("rmem_refetch");

      // Reset while a STORE drives MW high.
      applyStimulus((32'd4 << 26) | 32'($urandom_range(0, (1 << 26) - 1)), 4'd0, "rst_fetch");
      tick("rst_decode");
      tick("rst_store_exec");
      check_value("store_mw", 64'(bus.MW), 64'd1);
      async_reset("rst_in_store");
      tick("rst_refetch");

      // HALT holds across ten cycles while IR keeps changing, and only rst
      // releases it.
      applyStimulus(32'hFC00_0000, 4'd0, "halt_fetch");
      tick("halt_decode");
      tick("halt_exec");
      tick("halt_enter");
      check_value("halt_state", 64'(bus.state), 64'd5);
      for (int c = 0; c < 10; c++) begin
         bus.IR = $urandom;
         tick("halt_hold");
         check_value("halt_flag", 64'(bus.halted), 64'd1);
      end
      async_reset("rst_in_halt");
      check_value("unhalt_flag", 64'(bus.halted), 64'd0);
      tick("unhalt_fetch");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
